// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential non-restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/addsub_unit.sv
// W-bit adder/subtractor: y = a + b when sub=0, y = a + ~b + 1 when sub=1; carry out dropped.
module addsub_unit #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    logic [W-1:0] b_x;
    logic [W-1:0] cin;

    assign b_x = b ^ {W{sub}};
    assign cin = {{(W-1){1'b0}}, sub};
    assign y   = a + b_x + cin;

endmodule

// File: rtl/nonrestoring_divider.sv
// Multi-cycle unsigned non-restoring divider with start/done handshake and divide-by-zero flag.
module nonrestoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted_a;
    logic [WIDTH:0]   as_a;
    logic             as_sub;
    logic [WIDTH:0]   as_y;

    // The single add/sub is shared: RUN feeds the shifted remainder and steers by the old sign,
    // FIX feeds the unshifted remainder and always adds back.
    assign shifted_a = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign as_a      = (state_q == RUN) ? shifted_a : a_q;
    assign as_sub    = (state_q == RUN) && !a_q[WIDTH];

    addsub_unit #(.W(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   ({1'b0, m_q}),
        .sub (as_sub),
        .y   (as_y)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = dividend;
                    m_d     = divisor;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (divisor == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                a_d   = as_y;
                q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (a_q[WIDTH]) begin
                    a_d = as_y;
                end
                quot_d  = q_q;
                rem_d   = a_q[WIDTH] ? as_y[WIDTH-1:0] : a_q[WIDTH-1:0];
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ZERO: begin
                // Q still holds the captured dividend, which is reported as the remainder.
                quot_d  = '1;
                rem_d   = q_q;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider (WIDTH=4): directed vectors, reset abort, full sweep.
module tb_nonrestoring_divider;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           gap;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    logic prev_done = 1'b0;

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            chk("done_not_back_to_back", int'(prev_done), 0);
            chk("busy_low_at_done", int'(busy), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("quotient", int'(quotient), int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
                if (e.gap != 0) chk("done_spacing", cyc - last_done_cyc, e.gap);
            end
            last_done_cyc = cyc;
        end
        prev_done = rst_n && done;
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic run_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                           input bit inject);
        int lat;
        int busy_cnt;
        bit got;
        wait_idle();
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        sb.push_back('{q: eq, r: er, dbz: ez, gap: 0});
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~dvd;
        divisor  = ~dvs;
        chk("busy_after_accept", int'(busy), 1);
        lat = 0;
        busy_cnt = 1;
        got = 0;
        while (!got && lat < 20) begin
            if (inject && lat == 2) begin
                start    = 1'b1;
                dividend = 4'd12;
                divisor  = 4'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
            if (done) got = 1;
        end
        chk("done_latency", lat, (dvs == '0) ? 1 : W + 1);
        chk("busy_cycles", busy_cnt, (dvs == '0) ? 1 : W + 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors, expected values hand-computed
        run_div(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 1'b0);
        run_div(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 1'b0);
        run_div(4'd5,  4'd7,  4'd0,  4'd5, 1'b0, 1'b0);
        run_div(4'd0,  4'd9,  4'd0,  4'd0, 1'b0, 1'b0);
        run_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 1'b0);
        run_div(4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1'b0);
        run_div(4'd8,  4'd2,  4'd4,  4'd0, 1'b0, 1'b0);
        // start pulsed with 12/5 while busy must be ignored
        run_div(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 1'b1);

        // Reset asserted mid-operation abandons 14/4
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b0);

        // Exhaustive back-to-back sweep with start held high
        wait_idle();
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int dvd;
            int dvs;
            int k;
            exp_t e;
            dvd = i / 16;
            dvs = i % 16;
            dividend = W'(dvd);
            divisor  = W'(dvs);
            e.q   = (dvs == 0) ? 4'hF : W'(dvd / dvs);
            e.r   = (dvs == 0) ? W'(dvd) : W'(dvd % dvs);
            e.dbz = (dvs == 0);
            e.gap = (i == 0) ? 0 : ((dvs == 0) ? 2 : W + 2);
            sb.push_back(e);
            @(posedge clk);
            #1;
            k = 0;
            while (busy && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (k >= 20) chk("sweep_timeout", 1, 0);
        end
        start = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
